// File: rtl/two_to_one_mux_arbiter_module_if.sv
// Shared-path bus between two requesters and the 2:1 mux arbiter.
// MUX_ARB_LOCK_EN adds the holder lock signal.
interface two_to_one_mux_arbiter_module_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req_a;
    logic                  req_b;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
`ifdef MUX_ARB_LOCK_EN
    logic                  lock;
`endif
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  s;
    logic [DATA_WIDTH-1:0] out;
    logic                  out_valid;

    modport master (
        output req_a, req_b, data_a, data_b,
`ifdef MUX_ARB_LOCK_EN
        output lock,
`endif
        input  gnt_a, gnt_b, s, out, out_valid
    );

    modport slave (
        input  req_a, req_b, data_a, data_b,
`ifdef MUX_ARB_LOCK_EN
        input  lock,
`endif
        output gnt_a, gnt_b, s, out, out_valid
    );
endinterface

// File: rtl/two_to_one_mux_arbiter_module.sv
// Round-robin arbiter with bounded hold driving a gate-level 2:1 mux; grant one edge after request, data one edge after grant.
// No backpressure: requests are level-sensitive. MUX_ARB_LOCK_EN lets the holder suppress hold-time preemption.
module two_to_one_mux_arbiter_module #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    two_to_one_mux_arbiter_module_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD - 1);

    state_t                state_q, state_d;
    logic [3:0]            hold_q, hold_d;
    logic                  last_q, last_d;     // 1 = B was granted last
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_valid_q;
    logic                  lock_a, lock_b;
    logic                  sel;
    logic                  sel_n;
    logic [DATA_WIDTH-1:0] din_a, din_b, mux_y;

`ifdef MUX_ARB_LOCK_EN
    assign lock_a = bus.lock & bus.req_a;
    assign lock_b = bus.lock & bus.req_b;
`else
    assign lock_a = 1'b0;
    assign lock_b = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.req_a && bus.req_b) state_d = last_q ? GRANT_A : GRANT_B;
                else if (bus.req_a)         state_d = GRANT_A;
                else if (bus.req_b)         state_d = GRANT_B;
            end
            GRANT_A: begin
                if (!bus.req_a)                                      state_d = bus.req_b ? GRANT_B : IDLE;
                else if (bus.req_b && hold_q == HOLD_MAX && !lock_a) state_d = GRANT_B;
            end
            GRANT_B: begin
                if (!bus.req_b)                                      state_d = bus.req_a ? GRANT_A : IDLE;
                else if (bus.req_a && hold_q == HOLD_MAX && !lock_b) state_d = GRANT_A;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)      hold_d = 4'd0;
        else if (hold_q != HOLD_MAX) hold_d = hold_q + 4'd1;

        if (state_d == GRANT_A && state_q != GRANT_A) last_d = 1'b0;
        if (state_d == GRANT_B && state_q != GRANT_B) last_d = 1'b1;
    end

    // Datapath select follows the registered state, so it matches s.
    assign sel   = (state_q == GRANT_B);
    assign din_a = bus.data_a;
    assign din_b = bus.data_b;

    not u_sel_n (sel_n, sel);
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mux
        logic term_a, term_b;
        and u_and_a (term_a, din_a[i], sel_n);
        and u_and_b (term_b, din_b[i], sel);
        or  u_or    (mux_y[i], term_a, term_b);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= 4'd0;
            last_q      <= 1'b1;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            if (state_q != IDLE) begin
                out_q       <= mux_y;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.gnt_a     = (state_q == GRANT_A);
    assign bus.gnt_b     = (state_q == GRANT_B);
    assign bus.s         = sel;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_two_to_one_mux_arbiter_module.sv
// Directed self-checking bench for the 2:1 mux arbiter; observes {gnt_a, gnt_b, s, out_valid, out}.
module tb_two_to_one_mux_arbiter_module;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    two_to_one_mux_arbiter_module_if #(.DATA_WIDTH(8)) bus ();

    two_to_one_mux_arbiter_module #(.DATA_WIDTH(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {bus.gnt_a, bus.gnt_b, bus.s, bus.out_valid, bus.out};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input logic ra, input logic rb);
        reset = 1'b1;
        bus.req_a = ra;
        bus.req_b = rb;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        bus.data_a = 8'h33;
        bus.data_b = 8'h44;
        hold_reset(1'b1, 1'b1);
        got = obs();
        if (got !== 12'b0000_0000_0000) begin
            n_err++; $display("FAIL reset_values: got %h want %h", got, 12'h000);
        end
        n_vec++;
        step();
        got = obs();
        if (got !== {4'b1000, 8'h00}) begin
            n_err++; $display("FAIL reset_first_grant: got %h want %h", got, {4'b1000, 8'h00});
        end
        n_vec++;
    endtask

    task automatic test_single();
        logic [11:0] got, exp;
        bus.data_a = 8'h5A;
        bus.data_b = 8'hEE;
        hold_reset(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            got = obs();
            exp = (k == 1) ? {4'b1000, 8'h00} : {4'b1001, 8'h5A};
            if (got !== exp) begin
                n_err++; $display("FAIL single_req cycle %0d: got %h want %h", k, got, exp);
            end
            n_vec++;
        end
    endtask

    task automatic test_contention();
        logic [11:0] got, exp;
        logic        a_now, a_prev;
        bus.data_a = 8'h11;
        bus.data_b = 8'h22;
        hold_reset(1'b1, 1'b1);
        a_prev = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            a_now = (((k - 1) / 4) % 2) == 0;
            exp[11:8] = {a_now, !a_now, !a_now, (k > 1)};
            exp[7:0]  = (k == 1) ? 8'h00 : (a_prev ? 8'h11 : 8'h22);
            got = obs();
            if (got !== exp) begin
                n_err++; $display("FAIL contention cycle %0d: got %h want %h", k, got, exp);
            end
            n_vec++;
            a_prev = a_now;
        end
    endtask

    task automatic test_handoff();
        logic [11:0] got;
        bus.data_a = 8'h11;
        bus.data_b = 8'h22;
        hold_reset(1'b1, 1'b0);
        step();
        step();
        bus.req_a = 1'b0;
        bus.req_b = 1'b1;
        step();
        got = obs();
        if (got !== {4'b0111, 8'h11}) begin
            n_err++; $display("FAIL handoff_a_to_b: got %h want %h", got, {4'b0111, 8'h11});
        end
        n_vec++;
        step();
        got = obs();
        if (got !== {4'b0111, 8'h22}) begin
            n_err++; $display("FAIL handoff_b_data: got %h want %h", got, {4'b0111, 8'h22});
        end
        n_vec++;
        bus.req_b = 1'b0;
        step();
        got = obs();
        if (got !== {4'b0001, 8'h22}) begin
            n_err++; $display("FAIL release_to_idle: got %h want %h", got, {4'b0001, 8'h22});
        end
        n_vec++;
        step();
        got = obs();
        if (got !== {4'b0000, 8'h22}) begin
            n_err++; $display("FAIL idle_out_hold: got %h want %h", got, {4'b0000, 8'h22});
        end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        logic [11:0] got;
        bus.data_a = 8'h11;
        bus.data_b = 8'h22;
        hold_reset(1'b1, 1'b1);
        for (int k = 0; k < 7; k++) step();
        got = obs();
        if (got !== {4'b0111, 8'h22}) begin
            n_err++; $display("FAIL pre_reset_grant_b: got %h want %h", got, {4'b0111, 8'h22});
        end
        n_vec++;
        reset = 1'b1;
        step();
        got = obs();
        if (got !== 12'h000) begin
            n_err++; $display("FAIL reset_mid_grant: got %h want %h", got, 12'h000);
        end
        n_vec++;
        reset = 1'b0;
        step();
        got = obs();
        if (got !== {4'b1000, 8'h00}) begin
            n_err++; $display("FAIL post_reset_a_first: got %h want %h", got, {4'b1000, 8'h00});
        end
        n_vec++;
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        logic [11:0] got, exp;
        bus.data_a = 8'h11;
        bus.data_b = 8'h22;
        bus.lock   = 1'b1;
        hold_reset(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step();
            got = obs();
            exp = (k == 1) ? {4'b1000, 8'h00} : {4'b1001, 8'h11};
            if (got !== exp) begin
                n_err++; $display("FAIL lock_hold cycle %0d: got %h want %h", k, got, exp);
            end
            n_vec++;
        end
        bus.lock = 1'b0;
        step();
        got = obs();
        if (got !== {4'b0111, 8'h11}) begin
            n_err++; $display("FAIL lock_release: got %h want %h", got, {4'b0111, 8'h11});
        end
        n_vec++;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 8'h00;
        bus.data_b = 8'h00;
`ifdef MUX_ARB_LOCK_EN
        bus.lock   = 1'b0;
`endif
        test_reset();
        test_single();
        test_contention();
        test_handoff();
        test_reset_mid();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/two_to_one_mux_arbiter_module.md
Name: two_to_one_mux_arbiter_module

Overview:
- Sequential controller that shares one 2:1 mux datapath between two requesters, A and B.
- Arbitrates between req_a and req_b using round-robin with a bounded hold time.
- Drives the mux select s and the one-hot grants.
- Registers the selected data onto out with a valid flag.
- Sits in front of the gate-level mux and sequences which source owns the shared output path each cycle.

Parameters:
- DATA_WIDTH, 8, width of data_a, data_b and out.
- MAX_HOLD, 4, maximum consecutive grant cycles for one requester while the other is requesting. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_a  input  1  requester A wants the shared path.
- req_b  input  1  requester B wants the shared path.
- data_a  input  DATA_WIDTH  requester A data (mux input a).
- data_b  input  DATA_WIDTH  requester B data (mux input b).
- gnt_a  output  1  registered grant to A.
- gnt_b  output  1  registered grant to B.
- s  output  1  registered mux select: 0 selects a, 1 selects b.
- out  output  DATA_WIDTH  registered shared-path data.
- out_valid  output  1  out holds data captured under a grant.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE.
  - gnt_a=0, gnt_b=0, s=0.
  - out=0, out_valid=0.
  - hold_cnt=0.
  - last=B, so A wins the first tie.
  - Reset asserted mid-grant drops the grant on that edge. No partial transfer is flagged valid.
- States: IDLE, GRANT_A, GRANT_B. Outputs decode from the registered state:
  - gnt_a=1 only in GRANT_A.
  - gnt_b=1 only in GRANT_B.
  - s=1 only in GRANT_B, otherwise 0.
- IDLE transitions:
  - req_a & req_b: grant the one that is not last.
  - req_a only: GRANT_A.
  - req_b only: GRANT_B.
  - Neither: stay in IDLE.
- GRANT_A transitions:
  - !req_a & req_b: GRANT_B.
  - !req_a & !req_b: IDLE.
  - req_a & req_b & hold_cnt==MAX_HOLD-1: GRANT_B (preemption).
  - Otherwise: stay.
- GRANT_B: mirror of GRANT_A.
- last: updated to the granted side on every entry into GRANT_A or GRANT_B.
- hold_cnt:
  - Cleared on any state change.
  - Increments each cycle the state holds, saturating at MAX_HOLD-1.
  - With no competing request, the holder keeps the grant indefinitely; the counter stays saturated.
  - Preemption requires the competitor to be requesting on the preemption edge.
- Switching:
  - Direct A<->B switch with no IDLE bubble.
  - Grants are never both high.
  - Changing grant takes one edge: request change at edge N is seen in gnt at edge N+1.
- Data path:
  - On each edge where the current state is GRANT_A or GRANT_B: out <= (s ? data_b : data_a) and out_valid <= 1.
  - In IDLE: out holds its value and out_valid <= 0.
  - Latency: data presented in the first grant cycle appears on out one cycle later.
- Mux construction: the select/data mux uses the existing gate-level 2:1 mux instantiated per bit. No behavioural ?: is used for the datapath.
- Requests are level-sensitive. A requester may drop its request in any cycle. Its grant falls on the next edge.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While the current holder asserts lock together with its req, MAX_HOLD preemption is suppressed and hold_cnt keeps saturating.
  - Dropping req still releases the grant even if lock is high.
  - lock is ignored in IDLE.
- Undefined:
  - The lock port is absent.
  - Preemption always applies at MAX_HOLD.

Test Plan:
- Reset behaviour: hold reset 2 cycles with req_a=req_b=1 -> gnt_a=gnt_b=0, s=0, out=0, out_valid=0. On the first edge after release, gnt_a=1.
- Single requester: req_a=1 only, data_a=8'h5A for 10 cycles -> gnt_a stays 1, s=0, out=8'h5A from the cycle after grant, out_valid=1 throughout. The grant never toggles.
- Contention, MAX_HOLD=4: req_a=req_b=1 continuously -> gnt_a high 4 cycles, then gnt_b high 4 cycles, alternating. s toggles accordingly, and out tracks data_a=8'h11 / data_b=8'h22 one cycle late.
- Release handoff: in GRANT_A, drop req_a with req_b=1 -> gnt_b=1 and s=1 on the next edge, with no IDLE cycle. Then drop req_b -> IDLE, out_valid=0, out holds 8'h22.
- Reset mid-operation: assert reset during GRANT_B at hold_cnt=2 -> all outputs return to reset values on that edge. After release with both requesting, A is granted first.
- Lock (MUX_ARB_LOCK_EN defined): req_a=req_b=1, lock=1 while A holds -> gnt_a held 10 cycles with no preemption. Drop lock -> gnt_b on the next edge, because hold_cnt is already saturated.
